seg_display_scanner: RTL and testbench

- Downstream display stage of the calculator: consumes a num_t result from the calc core and drives a time-multiplexed 7-segment display of NumDigits digit positions plus one sign/error position.
- Double-buffers the value and swaps only at frame boundaries, so the display never tears.
- Does leading-zero blanking, decimal-point placement, and minus/error indication.
- Per-slot ghosting blank.

---
 rtl/seg_display_scanner_pkg.sv | 77 +++++++
 rtl/seg_scan_timer.sv | 44 ++++
 rtl/seg_display_scanner.sv | 90 +++++++++
 tb/tb_seg_display_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scanner_pkg.sv
// Shared types and glyph helpers for the multiplexed 7-segment display scanner.
// num_t carries a BCD significand, a fractional-digit count, sign and error flags.
package seg_display_scanner_pkg;

  localparam int unsigned NumDigits = 8;
  localparam int unsigned DigitW    = $clog2(NumDigits);
  localparam int unsigned ExpW      = DigitW + 1;
  localparam int unsigned NumSlots  = NumDigits + 1;
  localparam int unsigned SlotW     = $clog2(NumSlots);

  typedef struct packed {
    logic                      error;
    logic                      sign;
    logic [ExpW-1:0]           exponent;
    logic [NumDigits-1:0][3:0] significand;
  } num_t;

  localparam int unsigned NumBits = $bits(num_t);

  typedef struct packed {
    logic [6:0] segments;
    logic       dp;
  } glyph_t;

  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_E     = 7'b1001111;

  // Segment order is a..g from bit 6 down to bit 0; non-decimal codes stay dark.
  function automatic logic [6:0] bcd2segments(logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  function automatic glyph_t num2glyph(num_t num, logic [SlotW-1:0] idx);
    glyph_t g;
    logic   any_nonzero;
    logic   nonzero_at_or_above;
    g           = '0;
    any_nonzero = |num.significand;
    if (idx == SlotW'(NumDigits)) begin
      if (num.error) begin
        g.segments = SEG_E;
      end else if (num.sign && any_nonzero) begin
        g.segments = SEG_MINUS;
      end
    end else if (!num.error) begin
      nonzero_at_or_above = 1'b0;
      for (int j = 0; j < NumDigits; j++) begin
        if (j >= int'(idx) && num.significand[j] != 4'd0) begin
          nonzero_at_or_above = 1'b1;
        end
      end
      // Slot 0 can never exceed the exponent, so it is never blanked.
      if (int'(idx) > int'(num.exponent) && !nonzero_at_or_above) begin
        g.segments = '0;
      end else begin
        g.segments = bcd2segments(num.significand[idx[DigitW-1:0]]);
      end
      g.dp = (int'(idx) == int'(num.exponent));
    end
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/cycle counter for the display scan: slot index, per-slot blanking window
// and terminal-count pulses for the last cycle of a slot and of a frame.
module seg_scan_timer #(
  parameter int unsigned DigitCycles = 1000,
  parameter int unsigned NumSlots    = 9,
  parameter int unsigned BlankCycles = 1,
  localparam int unsigned CntW       = $clog2(DigitCycles),
  localparam int unsigned SlotW      = $clog2(NumSlots)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [SlotW-1:0] slot_o,
  output logic             in_blank_o,
  output logic             slot_last_o,
  output logic             frame_last_o
);

  logic [CntW-1:0]  cnt_d, cnt_q;
  logic [SlotW-1:0] slot_d, slot_q;

  always_comb begin
    slot_last_o  = (cnt_q == CntW'(DigitCycles - 1));
    frame_last_o = slot_last_o && (slot_q == SlotW'(NumSlots - 1));
    in_blank_o   = (32'(cnt_q) < BlankCycles);
    slot_o       = slot_q;

    cnt_d  = slot_last_o ? '0 : cnt_q + 1'b1;
    slot_d = slot_q;
    if (slot_last_o) begin
      slot_d = frame_last_o ? '0 : slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 7-segment driver: NumDigits digit positions plus a sign/error
// position, double-buffered so a new value only appears at a frame boundary.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int unsigned DigitCycles = 1000,
  parameter int unsigned BlankCycles = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumBits-1:0]   num_i,
  input  logic                 load_i,
  input  logic                 blank_i,
  output logic [6:0]           segments_o,
  output logic                 dp_o,
  output logic [NumDigits:0]   digit_en_o,
  output logic                 frame_done_o
);

  logic [SlotW-1:0] slot;
  logic             in_blank;
  logic             slot_last;
  logic             frame_last;

  seg_scan_timer #(
    .DigitCycles (DigitCycles),
    .NumSlots    (NumSlots),
    .BlankCycles (BlankCycles)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .slot_o       (slot),
    .in_blank_o   (in_blank),
    .slot_last_o  (slot_last),
    .frame_last_o (frame_last)
  );

  num_t   num_in;
  num_t   pending_d, pending_q;
  num_t   display_d, display_q;
  glyph_t glyph;

  logic [6:0]       segments_d, segments_q;
  logic             dp_d, dp_q;
  logic [NumDigits:0] digit_en_d, digit_en_q;
  logic             frame_done_d, frame_done_q;

  assign num_in = num_t'(num_i);
  assign glyph  = num2glyph(display_q, slot);

  always_comb begin
    pending_d = load_i ? num_in : pending_q;
    // A load on the wrap cycle goes straight into the new frame.
    display_d = frame_last ? pending_d : display_q;

    segments_d   = '0;
    dp_d         = 1'b0;
    digit_en_d   = '0;
    frame_done_d = slot_last && (slot == SlotW'(NumDigits));
    if (!blank_i && !in_blank) begin
      digit_en_d = NumSlots'(1) << slot;
      segments_d = glyph.segments;
      dp_d       = glyph.dp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q    <= '0;
      display_q    <= '0;
      segments_q   <= '0;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      display_q    <= display_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments_o   = segments_q;
  assign dp_o         = dp_q;
  assign digit_en_o   = digit_en_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench: a cycle-level reference model of the scanner, directed
// scenarios followed by randomized loads/blanks/resets.
module tb_seg_display_scanner;
  import seg_display_scanner_pkg::*;

  localparam int DC = 4;
  localparam int BC = 1;
  localparam int NS = 9;
  localparam int FL = NS * DC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  num_t       num = '0;
  logic [6:0] segments;
  logic       dp;
  logic [8:0] digit_en;
  logic       frame_done;

  always #5 clk = ~clk;

  seg_display_scanner #(
    .DigitCycles (DC),
    .BlankCycles (BC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .num_i        (num),
    .load_i       (load),
    .blank_i      (blank),
    .segments_o   (segments),
    .dp_o         (dp),
    .digit_en_o   (digit_en),
    .frame_done_o (frame_done)
  );

  int checks = 0;
  int passes = 0;

  logic [6:0] seg_tab [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic num_t mk(input logic e, input logic s, input int x, input logic [31:0] sig);
    num_t n;
    n.error       = e;
    n.sign        = s;
    n.exponent    = ExpW'(x);
    n.significand = sig;
    return n;
  endfunction

  // Glyph at position s: digits shown up to the most significant nonzero digit
  // or the decimal point, whichever is higher.
  task automatic model_glyph(input num_t n, input int s, output logic [6:0] seg,
                             output logic p);
    int         msd;
    logic [3:0] d;
    msd = -1;
    for (int j = 0; j < NS - 1; j++) if (n.significand[j] != 0) msd = j;
    seg = '0;
    p   = 1'b0;
    if (s == NS - 1) begin
      if (n.error) seg = 7'b1001111;
      else if (n.sign && msd >= 0) seg = 7'b0000001;
    end else if (!n.error) begin
      d = n.significand[3'(s)];
      if (s <= msd || s <= int'(n.exponent)) seg = seg_tab[d];
      p = (s == int'(n.exponent));
    end
  endtask

  // Reference model: k is the index of the scan state consumed at the next edge.
  int         k = 0;
  num_t       m_pend = '0;
  num_t       m_disp = '0;
  logic [6:0] e_seg = '0;
  logic       e_dp = 1'b0;
  logic [8:0] e_en = '0;
  logic       e_fd = 1'b0;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    int         slot, cnt;
    logic [6:0] g_seg;
    logic       g_dp;
    if (rst) begin
      k = 0; m_pend = '0; m_disp = '0;
      e_seg = '0; e_dp = 1'b0; e_en = '0; e_fd = 1'b0;
    end else begin
      slot = (k / DC) % NS;
      cnt  = k % DC;
      model_glyph(m_disp, slot, g_seg, g_dp);
      e_fd = ((k % FL) == FL - 1);
      if (blank || cnt < BC) begin
        e_seg = '0; e_dp = 1'b0; e_en = '0;
      end else begin
        e_seg = g_seg; e_dp = g_dp; e_en = 9'(1) << slot;
      end
      if (load) m_pend = num;
      if ((k % FL) == FL - 1) m_disp = m_pend;
      k++;
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid)
      check("outputs{seg,dp,en,fd}", {segments, dp, digit_en, frame_done},
            {e_seg, e_dp, e_en, e_fd});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input num_t v);
    num  = v;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic pin(input string name, input num_t n, input int s, input logic [7:0] exp);
    logic [6:0] seg;
    logic       p;
    model_glyph(n, s, seg, p);
    check(name, {seg, p}, exp);
  endtask

  initial begin
    bit   found;
    num_t r;
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b0, 7'b0, 7'b0, 7'b0,
                7'b0, 7'b0};

    pin("pin_1234_s0", mk(0, 0, 2, 32'h1234), 0, {7'b0110011, 1'b0});
    pin("pin_1234_s2", mk(0, 0, 2, 32'h1234), 2, {7'b1101101, 1'b1});
    pin("pin_1234_s3", mk(0, 0, 2, 32'h1234), 3, {7'b0110000, 1'b0});
    pin("pin_1234_s4", mk(0, 0, 2, 32'h1234), 4, {7'b0000000, 1'b0});
    pin("pin_n42_s5", mk(0, 1, 5, 32'h42), 5, {7'b1111110, 1'b1});
    pin("pin_n42_s6", mk(0, 1, 5, 32'h42), 6, {7'b0000000, 1'b0});
    pin("pin_n42_s8", mk(0, 1, 5, 32'h42), 8, {7'b0000001, 1'b0});
    pin("pin_negzero_s8", mk(0, 1, 0, 32'h0), 8, {7'b0000000, 1'b0});
    pin("pin_zero_s0", mk(0, 0, 0, 32'h0), 0, {7'b1111110, 1'b1});
    pin("pin_err_s8", mk(1, 1, 2, 32'h1234), 8, {7'b1001111, 1'b0});
    pin("pin_err_s0", mk(1, 0, 0, 32'h1234), 0, {7'b0000000, 1'b0});
    pin("pin_bcd_a_s0", mk(0, 0, 1, 32'hA), 0, {7'b0000000, 1'b0});

    cycles(3);
    rst = 1'b0;
    cycles(40);
    pulse_load(mk(0, 0, 2, 32'h00001234));
    cycles(80);
    pulse_load(mk(0, 1, 5, 32'h00000042));
    cycles(80);
    pulse_load(mk(0, 1, 3, 32'h0));
    cycles(80);
    pulse_load(mk(1, 0, 0, 32'h00000777));
    cycles(40);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if ((k % FL) == FL - 1) found = 1'b1;
      else @(negedge clk);
    end
    check("wrap_cycle_found", 32'(found), 32'd1);
    pulse_load(mk(0, 0, 1, 32'h00098765));
    cycles(45);

    cycles(6);
    blank = 1'b1;
    cycles(50);
    blank = 1'b0;
    cycles(40);

    cycles(13);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(80);

    repeat (3000) begin
      r.error       = ($urandom_range(7) == 0);
      r.sign        = 1'($urandom);
      r.exponent    = ExpW'($urandom);
      r.significand = $urandom >> (4 * $urandom_range(7));
      if ($urandom_range(3) != 0)
        for (int j = 0; j < NS - 1; j++)
          if (r.significand[j] > 4'd9) r.significand[j] = 4'($urandom_range(9));
      num   = r;
      load  = ($urandom_range(11) == 0);
      if ($urandom_range(39) == 0) blank = ~blank;
      rst   = ($urandom_range(499) == 0);
      cycles(1);
    end
    rst   = 1'b0;
    load  = 1'b0;
    blank = 1'b0;
    cycles(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
